// File: rtl/ftile_ts_pkg.sv
// Shared types and defaults for the F-tile 25GbE TX timestamp bridge.
package ftile_ts_pkg;

   localparam int FP_WIDTH_DEFAULT = 20;
   localparam int TS_WIDTH_DEFAULT = 96;
   localparam int FP_DEPTH_DEFAULT = 16;

   // Completion returned to the DMA: fingerprint of the packet plus its egress timestamp.
   typedef struct packed {
      logic [FP_WIDTH_DEFAULT-1:0] fingerprint;
      logic [TS_WIDTH_DEFAULT-1:0] data;
   } ts_compl_t;

   // Packet framing tracker.
   typedef enum logic {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } frame_state_e;

endpackage

// File: rtl/ftile_ts_fp_fifo.sv
// Show-ahead fingerprint FIFO: rdata is the oldest entry whenever empty is low.
// A pop in the same cycle as a push into an empty FIFO is ignored (empty is registered state).
module ftile_ts_fp_fifo #(
   parameter int W     = 20,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic [W-1:0]             rdata
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] count_q, count_d;
   logic          push_ok, pop_ok;

   assign full    = (count_q == LW'(DEPTH));
   assign empty   = (count_q == '0);
   assign level   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/ftile_25gbe_tx_ts_bridge.sv
// TX bridge between the 25GbE DMA and the F-tile MAC client: registers the packet
// stream, queues fingerprints of timestamp-requesting packets and pairs each MAC
// egress timestamp with the oldest queued fingerprint.
// Optional: TX_TS_BRIDGE_STATS_EN builds the drop/orphan saturating counters.
//
// state  | meaning
// IDLE   | between packets; only SOP beats are forwarded, others dropped
// IN_PKT | inside a packet; every beat forwarded until EOP
module ftile_25gbe_tx_ts_bridge
   import ftile_ts_pkg::*;
#(
   parameter int FP_WIDTH = FP_WIDTH_DEFAULT,
   parameter int TS_WIDTH = TS_WIDTH_DEFAULT,
   parameter int FP_DEPTH = FP_DEPTH_DEFAULT
) (
   input  logic                      clk_clk,
   input  logic                      reset_reset,
   output logic                      in_st_ready,
   input  logic                      in_st_valid,
   input  logic                      in_st_startofpacket,
   input  logic                      in_st_endofpacket,
   input  logic [63:0]               in_st_data,
   input  logic [2:0]                in_st_empty,
   input  logic                      in_st_error,
   input  logic                      in_ts_req_valid,
   input  logic [FP_WIDTH-1:0]       in_ts_req_fingerprint,
   input  logic                      out_st_ready,
   output logic                      out_st_valid,
   output logic                      out_st_startofpacket,
   output logic                      out_st_endofpacket,
   output logic [63:0]               out_st_data,
   output logic [2:0]                out_st_empty,
   output logic                      out_st_error,
   output logic                      out_st_ts_req,
   input  logic                      mac_ts_valid,
   input  logic [TS_WIDTH-1:0]       mac_ts_data,
   output logic                      o_ts_valid,
   output logic [FP_WIDTH-1:0]       o_ts_fingerprint,
   output logic [TS_WIDTH-1:0]       o_ts_data,
   output logic [$clog2(FP_DEPTH):0] fp_level,
   output logic                      framing_err,
   output logic                      orphan_err,
   output logic [15:0]               drop_cnt,
   output logic [15:0]               orphan_cnt
);

   frame_state_e          state_q, state_d;

   logic                  out_valid_q,  out_valid_d;
   logic                  out_sop_q,    out_sop_d;
   logic                  out_eop_q,    out_eop_d;
   logic [63:0]           out_data_q,   out_data_d;
   logic [2:0]            out_empty_q,  out_empty_d;
   logic                  out_error_q,  out_error_d;
   logic                  out_ts_req_q, out_ts_req_d;

   logic                  o_ts_valid_q, o_ts_valid_d;
   logic [FP_WIDTH-1:0]   o_ts_fp_q,    o_ts_fp_d;
   logic [TS_WIDTH-1:0]   o_ts_data_q,  o_ts_data_d;

   logic                  framing_err_q, framing_err_d;
   logic                  orphan_err_q,  orphan_err_d;

   logic                  sop, eop, accept, fwd, push, pop, orphan, load;
   logic                  fp_full, fp_empty;
   logic [FP_WIDTH-1:0]   fp_rdata;

   assign sop    = in_st_startofpacket;
   assign eop    = in_st_endofpacket;
   // Ready is held low during reset even though the output register is already empty.
   assign in_st_ready = ~reset_reset & (~out_valid_q | out_st_ready) & ~fp_full;
   assign accept = in_st_valid & in_st_ready;
   assign fwd    = accept & (sop | (state_q == IN_PKT));
   assign push   = accept & sop & in_ts_req_valid;
   assign pop    = mac_ts_valid & ~fp_empty;
   assign orphan = mac_ts_valid & fp_empty;
   assign load   = ~out_valid_q | out_st_ready;

   ftile_ts_fp_fifo #(
      .W     (FP_WIDTH),
      .DEPTH (FP_DEPTH)
   ) u_fp_fifo (
      .clk   (clk_clk),
      .rst   (reset_reset),
      .push  (push),
      .wdata (in_ts_req_fingerprint),
      .pop   (pop),
      .full  (fp_full),
      .empty (fp_empty),
      .level (fp_level),
      .rdata (fp_rdata)
   );

   // Framing FSM next state and sticky framing error.
   always_comb begin
      state_d       = state_q;
      framing_err_d = framing_err_q;
      if (accept) begin
         case (state_q)
            IDLE: begin
               if (sop && !eop) state_d = IN_PKT;
            end
            IN_PKT: begin
               if (sop) framing_err_d = 1'b1;
               if (eop) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Output register: reload when empty or drained, otherwise hold under backpressure.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_sop_d    = out_sop_q;
      out_eop_d    = out_eop_q;
      out_data_d   = out_data_q;
      out_empty_d  = out_empty_q;
      out_error_d  = out_error_q;
      out_ts_req_d = out_ts_req_q;
      if (load) begin
         out_valid_d = fwd;
         if (fwd) begin
            out_sop_d    = sop;
            out_eop_d    = eop;
            out_data_d   = in_st_data;
            out_empty_d  = in_st_empty;
            out_error_d  = in_st_error | ((state_q == IN_PKT) & sop);
            out_ts_req_d = sop & in_ts_req_valid;
         end
      end
   end

   // Completion pairing and sticky orphan flag.
   always_comb begin
      o_ts_valid_d = pop;
      o_ts_fp_d    = o_ts_fp_q;
      o_ts_data_d  = o_ts_data_q;
      orphan_err_d = orphan_err_q | orphan;
      if (pop) begin
         o_ts_fp_d   = fp_rdata;
         o_ts_data_d = mac_ts_data;
      end
   end

   // State, datapath and status registers.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_q       <= IDLE;
         out_valid_q   <= 1'b0;
         out_sop_q     <= 1'b0;
         out_eop_q     <= 1'b0;
         out_data_q    <= '0;
         out_empty_q   <= '0;
         out_error_q   <= 1'b0;
         out_ts_req_q  <= 1'b0;
         o_ts_valid_q  <= 1'b0;
         o_ts_fp_q     <= '0;
         o_ts_data_q   <= '0;
         framing_err_q <= 1'b0;
         orphan_err_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         out_valid_q   <= out_valid_d;
         out_sop_q     <= out_sop_d;
         out_eop_q     <= out_eop_d;
         out_data_q    <= out_data_d;
         out_empty_q   <= out_empty_d;
         out_error_q   <= out_error_d;
         out_ts_req_q  <= out_ts_req_d;
         o_ts_valid_q  <= o_ts_valid_d;
         o_ts_fp_q     <= o_ts_fp_d;
         o_ts_data_q   <= o_ts_data_d;
         framing_err_q <= framing_err_d;
         orphan_err_q  <= orphan_err_d;
      end
   end

`ifdef TX_TS_BRIDGE_STATS_EN
   logic        drop;
   logic [15:0] drop_cnt_q,   drop_cnt_d;
   logic [15:0] orphan_cnt_q, orphan_cnt_d;

   assign drop = accept & ~sop & (state_q == IDLE);

   // Saturating event counters.
   always_comb begin
      drop_cnt_d   = drop_cnt_q;
      orphan_cnt_d = orphan_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF))     drop_cnt_d   = drop_cnt_q + 16'd1;
      if (orphan && (orphan_cnt_q != 16'hFFFF)) orphan_cnt_d = orphan_cnt_q + 16'd1;
   end

   // Counter registers.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         drop_cnt_q   <= '0;
         orphan_cnt_q <= '0;
      end else begin
         drop_cnt_q   <= drop_cnt_d;
         orphan_cnt_q <= orphan_cnt_d;
      end
   end

   assign drop_cnt   = drop_cnt_q;
   assign orphan_cnt = orphan_cnt_q;
`else
   assign drop_cnt   = '0;
   assign orphan_cnt = '0;
`endif

   assign out_st_valid         = out_valid_q;
   assign out_st_startofpacket = out_sop_q;
   assign out_st_endofpacket   = out_eop_q;
   assign out_st_data          = out_data_q;
   assign out_st_empty         = out_empty_q;
   assign out_st_error         = out_error_q;
   assign out_st_ts_req        = out_ts_req_q;
   assign o_ts_valid           = o_ts_valid_q;
   assign o_ts_fingerprint     = o_ts_fp_q;
   assign o_ts_data            = o_ts_data_q;
   assign framing_err          = framing_err_q;
   assign orphan_err           = orphan_err_q;

endmodule

// File: doc/ftile_25gbe_tx_ts_bridge.md
# ftile_25gbe_tx_ts_bridge

Sits between the 25GbE TX DMA subsystem's packet/timestamp-request outputs and the F-tile MAC TX client. It forwards the 64-bit Avalon-ST packet stream to the MAC through one register stage. It queues the fingerprint of every packet that requested a timestamp. It pairs each MAC egress timestamp with the oldest queued fingerprint and returns `{fingerprint, timestamp}` as a completion to the DMA's timestamp input.

## Interface
- `FP_WIDTH`, 20: fingerprint width.
- `TS_WIDTH`, 96: timestamp width.
- `FP_DEPTH`, 16: fingerprint queue depth; power of two, minimum 2.

Ports (name, direction, width, meaning):
- `clk_clk` in 1: single clock (ftile clock domain).
- `reset_reset` in 1: asynchronous, active-high reset.
- `in_st_ready` out 1: sink ready.
- `in_st_valid`, `in_st_startofpacket`, `in_st_endofpacket` in 1: sink qualifiers.
- `in_st_data` in 64: sink data.
- `in_st_empty` in 3: sink empty.
- `in_st_error` in 1: sink error.
- `in_ts_req_valid` in 1: packet requests a timestamp.
- `in_ts_req_fingerprint` in FP_WIDTH: fingerprint for that request.
- `out_st_ready` in 1: MAC ready.
- `out_st_valid`, `out_st_startofpacket`, `out_st_endofpacket` out 1: source qualifiers.
- `out_st_data` out 64: source data.
- `out_st_empty` out 3: source empty.
- `out_st_error` out 1: source error.
- `out_st_ts_req` out 1: the SOP beat belongs to a timestamped packet.
- `mac_ts_valid` in 1: MAC egress timestamp strobe.
- `mac_ts_data` in TS_WIDTH: MAC egress timestamp.
- `o_ts_valid` out 1: completion strobe to DMA.
- `o_ts_fingerprint` out FP_WIDTH: completion fingerprint.
- `o_ts_data` out TS_WIDTH: completion timestamp.
- `fp_level` out clog2(FP_DEPTH)+1: queued fingerprints.
- `framing_err` out 1: sticky.
- `orphan_err` out 1: sticky.
- `drop_cnt` out 16: beats discarded in IDLE.
- `orphan_cnt` out 16: timestamps with no queued fingerprint.

## Operation
- **Accept:** a beat is accepted when `in_st_valid & in_st_ready`.
- **Ready:** `in_st_ready = (!out_st_valid | out_st_ready) & !fp_full`. Ready is combinational from `out_st_ready` and the queue state.
- **Request sampling:** `in_ts_req_valid` is sampled only on an accepted SOP beat. At any other time it is ignored.
- **Framing FSM, IDLE:**
  - Accepted beat with SOP is forwarded. If it lacks EOP, go to IN_PKT.
  - Accepted beat without SOP is consumed, not forwarded, and `drop_cnt` increments.
- **Framing FSM, IN_PKT:**
  - Every accepted beat is forwarded. A beat with EOP returns the FSM to IDLE.
  - A beat with SOP sets `framing_err` and is forwarded with `out_st_error=1`. The FSM stays in IN_PKT unless that beat also has EOP.
- **Timestamp flag:** `out_st_ts_req` equals the sampled request on SOP beats and is 0 on all other beats.
- **Queue push:** happens on an accepted SOP beat with `in_ts_req_valid`.
- **Queue pop:** happens on `mac_ts_valid` when the queue is not empty.
- **Simultaneous push and pop:** both occur and `fp_level` is unchanged. A pop in the same cycle as a push into an empty queue does not see the new entry.
- **Orphan timestamp:** `mac_ts_valid` with an empty queue is discarded, sets `orphan_err`, and increments `orphan_cnt`.
- **Ordering:** MAC timestamps arrive in packet order; completions are in order.
- **Counters:** saturate at 0xFFFF. The sticky flags and counters clear only on reset.

## Timing
- **Reset values:** every output is 0, the FSM is in IDLE, and the queue is empty. During reset `in_st_ready` is 0.
- **Data path latency:** 1 cycle, from accepted input beat to `out_st_valid`. Full throughput holds when `out_st_ready` is held high.
- **Source hold:** source outputs hold stable while `out_st_valid & !out_st_ready`.
- **Completion latency:** 1 cycle, from `mac_ts_valid` to `o_ts_valid`. `o_ts_valid` is a single-cycle pulse per pop.
- **Back-to-back timestamps:** `mac_ts_valid` on consecutive cycles produces consecutive completions.
- **Full queue:** when `fp_level == FP_DEPTH`, `in_st_ready` is 0 for all beats. A pop in cycle N makes `in_st_ready` rise in cycle N+1.
- **Reset mid-packet:** the output register, FSM, and queue are cleared; no partial beat is re-emitted.

## Configuration
- **`TX_TS_BRIDGE_STATS_EN` defined:** `drop_cnt` and `orphan_cnt` are implemented as 16-bit saturating counters.
- **`TX_TS_BRIDGE_STATS_EN` undefined:**
  - The counters are not built and both ports are tied to 0.
  - The drop and orphan behaviour itself and the sticky flags are unchanged.

## Structure
- **Package `ftile_ts_pkg`:**
  - `FP_WIDTH` and `TS_WIDTH` defaults.
  - `ts_compl_t` struct `{fingerprint, data}`.
  - Framing state enum `{IDLE, IN_PKT}`.
- **Sub-module `ftile_ts_fp_fifo`:**
  - Synchronous FIFO of FP_WIDTH × FP_DEPTH, with async active-high reset.
  - Interface: `push`, `pop`, `full`, `empty`, `level`, `rdata`.
  - Read data is valid with `!empty`, i.e. a show-ahead FIFO.

## Test plan
- **Single timestamped packet:** 3-beat packet, SOP with req fingerprint 0x0ABCD, `out_st_ready=1`.
  - Output beats appear 1 cycle later, with `out_st_ts_req=1` on SOP only.
  - `mac_ts_valid` with data 0x1234 gives `o_ts_valid`, fingerprint 0x0ABCD, data 0x1234 one cycle later.
  - `fp_level` returns to 0.
- **Queue full:** 16 single-beat requested packets with no MAC timestamps.
  - `fp_level=16` and `in_st_ready=0`.
  - One `mac_ts_valid` returns the first fingerprint, and `in_st_ready` rises the next cycle.
- **Simultaneous push and pop:** push fingerprint 0x2 and pop in the same cycle with `fp_level=1`.
  - `fp_level` stays 1.
  - The completion carries the older fingerprint 0x1.
- **Framing errors:**
  - Beat without SOP in IDLE: not forwarded, `drop_cnt=1`.
  - SOP inside IN_PKT: forwarded with `out_st_error=1`, and `framing_err=1`.
- **Orphan timestamp:** `mac_ts_valid` with an empty queue.
  - No `o_ts_valid`, `orphan_err=1`, `orphan_cnt=1`.
  - With the macro undefined, `orphan_cnt` stays 0.
- **Backpressure and reset:**
  - `out_st_ready=0` mid-packet: outputs hold.
  - Reset asserted mid-packet: all outputs are 0 and the FSM returns to IDLE.
